// File: rtl/led_seq_ctrl.sv
// Avalon-MM slave that drives two status LEDs from manual bits, a shared blink
// timebase, or a count-limited burst FSM. Reads are combinational, writes take one edge.
module led_seq_ctrl #(
  parameter int          PRESCALE   = 50000,
  parameter int          PRESCALE_W = 16,
  parameter logic [7:0]  PERIOD_RST = 8'd250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic [1:0] led_out,
  output logic       burst_busy
);

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_t;

  localparam logic [PRESCALE_W-1:0] PRESC_MAX = PRESCALE_W'(PRESCALE - 1);

  // Bus handshake: a write is accepted on any edge where chipselect is high and
  // write_n is low; there is no wait-state or valid/ready back-pressure.
  logic wr_en, wr_manual, wr_mode, wr_period, wr_burst, burst_restart;
  assign wr_en         = chipselect && !write_n;
  assign wr_manual     = wr_en && (address == 2'd0);
  assign wr_mode       = wr_en && (address == 2'd1);
  assign wr_period     = wr_en && (address == 2'd2);
  assign wr_burst      = wr_en && (address == 2'd3);
  assign burst_restart = wr_burst && (writedata != 8'd0);

  logic [1:0]            manual_q;
  logic [3:0]            mode_q;
  logic [7:0]            period_q;
  logic [7:0]            remaining_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic [7:0]            hp_q;
  logic                  phase_q;
  state_t                state_q;
  logic [1:0]            led_q;
  logic [1:0]            led_d;

  logic       tick, phase_end;
  logic [7:0] p_eff;
  assign tick      = (presc_q == PRESC_MAX);
  assign p_eff     = (period_q == 8'd0) ? 8'd1 : period_q;
  assign phase_end = tick && (hp_q == (p_eff - 8'd1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      manual_q <= '0;
      mode_q   <= '0;
      period_q <= PERIOD_RST;
    end else begin
      if (wr_manual) manual_q <= writedata[1:0];
      if (wr_mode)   mode_q   <= writedata[3:0];
      if (wr_period) period_q <= writedata;
    end
  end

  // Timebase: a PERIOD write or a burst (re)start realigns the counters, so the
  // first half-period after either is always a full P_eff ticks long.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
      hp_q    <= '0;
      phase_q <= 1'b0;
    end else if (wr_period || burst_restart) begin
      presc_q <= '0;
      hp_q    <= '0;
      if (wr_period) phase_q <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PRESCALE_W'(1);
      if (phase_end) begin
        hp_q    <= '0;
        phase_q <= ~phase_q;
      end else if (tick) begin
        hp_q <= hp_q + 8'd1;
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < 2; i++) begin
      case (mode_q[2*i +: 2])
        2'b00:   led_d[i] = manual_q[i];
        2'b01:   led_d[i] = phase_q;
        2'b10:   led_d[i] = (state_q == S_ON);
        default: led_d[i] = 1'b0;
      endcase
    end
  end

  // Burst FSM; a BURST write always takes priority over a coincident phase_end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      led_q       <= '0;
    end else begin
      led_q <= led_d;
      if (wr_burst) begin
        if (writedata == 8'd0) begin
          state_q     <= S_IDLE;
          remaining_q <= '0;
        end else begin
          state_q     <= S_ON;
          remaining_q <= writedata;
        end
      end else if (phase_end) begin
        case (state_q)
          S_ON:  state_q <= S_OFF;
          S_OFF: begin
            if (remaining_q > 8'd1) begin
              state_q     <= S_ON;
              remaining_q <= remaining_q - 8'd1;
            end else begin
              state_q     <= S_IDLE;
              remaining_q <= '0;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign led_out    = led_q;
  assign burst_busy = (state_q != S_IDLE);

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = {6'd0, manual_q};
      2'd1:    readdata = {4'd0, mode_q};
      2'd2:    readdata = period_q;
      default: readdata = remaining_q;
    endcase
  end

endmodule
